mem_master: RTL and testbench
=============================

Name: mem_master

Overview:
- Bus initiator that drives the single-port `mem` block (`en`/`rd`/`wr`/`addr`/`data` in, `out` read data) on behalf of a CPU-side client.
- Accepts one read or write request at a time over a valid/ready handshake.
- Sequences the memory strobes with a configurable read wait, then returns a completion/read-data response over a second valid/ready handshake.
- Sits between the CPU datapath/fetch logic and `mem`.

Parameters:
- ADDR_W, 16, address width; matches `mem` addr.
- DATA_W, 32, data width; matches `mem` data/out.
- RD_WAIT, 0, extra cycles `rd` is held before `out` is sampled. Range 0..15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  client request valid.
- req_ready  output  1  block can accept a request.
- req_wr  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  request address.
- req_wdata  input  DATA_W  write data (ignored for reads).
- resp_valid  output  1  response valid.
- resp_ready  input  1  client accepts response.
- resp_wr  output  1  response is for a write (1) or read (0).
- resp_rdata  output  DATA_W  read data; 0 for write responses.
- busy  output  1  high in any state other than IDLE.
- mem_en  output  1  to `mem` en.
- mem_rd  output  1  to `mem` rd.
- mem_wr  output  1  to `mem` wr.
- mem_addr  output  ADDR_W  to `mem` addr.
- mem_data  output  DATA_W  to `mem` data (write data).
- mem_out  input  DATA_W  from `mem` out; valid only while mem_en & mem_rd.

Behaviour:
- One clock (clk); reset synchronous, active-low (rst_n); sampled only on rising clk.
- Reset values (cycle after rst_n=0 sampled):
  - state=IDLE; req_ready=1.
  - resp_valid=0, resp_wr=0, resp_rdata=0, busy=0.
  - mem_en=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_data=0.
  - wait counter=0.
- FSM states: IDLE, WRITE, READ, RESP. All outputs registered or decoded from state only; no combinational path from req_* to mem_*.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch addr→mem_addr, wdata→mem_data, wr flag.
  - Go WRITE if req_wr, else READ; load counter=RD_WAIT.
- WRITE:
  - mem_en=1, mem_wr=1, mem_rd=0 for exactly one cycle; `mem` commits on the closing edge.
  - Then RESP with resp_wr=1, resp_rdata=0.
- READ:
  - mem_en=1, mem_rd=1, mem_wr=0.
  - Counter decrements each cycle while nonzero.
  - On the edge where counter==0: capture mem_out→resp_rdata, go RESP with resp_wr=0.
  - Occupies RD_WAIT+1 cycles.
- RESP:
  - mem_en/rd/wr=0; resp_valid=1.
  - resp_rdata/resp_wr held stable until resp_valid&resp_ready; then IDLE.
  - req_ready=0, so no new request is accepted in the same cycle as the response handshake.
- Latency (request handshake at edge N):
  - Write: mem_wr high in cycle N+1; resp_valid at N+2.
  - Read: mem_rd high cycles N+1..N+1+RD_WAIT; resp_valid at N+2+RD_WAIT.
  - Minimum request-to-request spacing: write 3 cycles, read RD_WAIT+3 cycles, with resp_ready tied 1.
- mem_addr/mem_data hold their last latched value after an access (not cleared). Mem strobes are the only qualifiers.
- resp_ready held 0: block stays in RESP indefinitely; req_ready stays 0; no memory activity.
- req_valid while not ready: ignored. The client must hold the request stable; nothing is queued.
- Address wrap: none; addresses passed through unchanged. 0 and 2^ADDR_W-1 are legal.
- Reset mid-operation (any state): the in-flight request is dropped without response. Strobes fall on the next edge; the reset values above apply. A write is aborted only if rst_n is low on the same edge that would commit it; `mem` itself still sees wr high in that cycle, so the commit is the memory's responsibility.
- busy = (state != IDLE).

Test Plan:
- Reset then write addr=15 data=123, resp_ready=1:
  - mem_wr high for exactly 1 cycle with mem_addr=15, mem_data=123.
  - resp_valid at N+2 with resp_wr=1, resp_rdata=0.
- Read addr=15 after the above, RD_WAIT=0:
  - mem_rd high for 1 cycle.
  - resp_valid at N+2, resp_rdata=123, resp_wr=0.
- Write addr=16 data=223, then read addr=16 with RD_WAIT=3:
  - mem_rd high 4 consecutive cycles.
  - resp_rdata=223 at N+5.
  - mem_wr never high during the read.
- Read with resp_ready=0 for 5 cycles:
  - resp_valid and resp_rdata stable for all 5 cycles.
  - req_ready=0; a req_valid pulse in that window is ignored (no mem_en).
  - Response completes when resp_ready=1.
- Boundary addresses: write 0→0xFFFFFFFF and 0xFFFF→0x0000_0001, read both → exact values returned; no aliasing.
- Assert rst_n=0 during cycle 2 of a RD_WAIT=3 read:
  - Next edge: mem_en=0, busy=0, resp_valid=0, req_ready=1.
  - A following read of the same address completes normally.

Source files
------------

// File: rtl/mem_master.sv
// Single-request bus initiator for the single-port `mem` block. It sequences the
// memory strobes and returns a completion/read-data response over valid/ready.
module mem_master #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int RD_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_wr,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] RD_WAIT_C = 4'(RD_WAIT);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              resp_wr_q, resp_wr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            resp_wr_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            resp_wr_q <= resp_wr_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        resp_wr_d = resp_wr_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    data_d  = req_wdata;
                    cnt_d   = RD_WAIT_C;
                    state_d = req_wr ? WRITE : READ;
                end
            end
            WRITE: begin
                resp_wr_d = 1'b1;
                rdata_d   = '0;
                state_d   = RESP;
            end
            READ: begin
                // mem_out is sampled on the edge that ends the last rd cycle
                if (cnt_q == 4'd0) begin
                    resp_wr_d = 1'b0;
                    rdata_d   = mem_out;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Every handshake and strobe output decodes from the state register alone.
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign mem_en     = (state_q == WRITE) || (state_q == READ);
    assign mem_rd     = (state_q == READ);
    assign mem_wr     = (state_q == WRITE);
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;
    assign resp_wr    = resp_wr_q;
    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_master.sv
// Bench for mem_master: two instances (RD_WAIT=0 and RD_WAIT=3), each with a behavioural mem.
module tb_mem_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_n;
    logic [1:0]       req_valid, req_ready, req_wr;
    logic [1:0][15:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       resp_valid, resp_ready, resp_wr, busy;
    logic [1:0][31:0] resp_rdata;
    logic [1:0]       mem_en, mem_rd, mem_wr;
    logic [1:0][15:0] mem_addr;
    logic [1:0][31:0] mem_data, mem_out;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            logic [31:0] arr [0:65535];

            mem_master #(.ADDR_W(16), .DATA_W(32), .RD_WAIT(gi * 3)) u_dut (
                .clk(clk), .rst_n(rst_n[gi]),
                .req_valid(req_valid[gi]), .req_ready(req_ready[gi]), .req_wr(req_wr[gi]),
                .req_addr(req_addr[gi]), .req_wdata(req_wdata[gi]),
                .resp_valid(resp_valid[gi]), .resp_ready(resp_ready[gi]),
                .resp_wr(resp_wr[gi]), .resp_rdata(resp_rdata[gi]), .busy(busy[gi]),
                .mem_en(mem_en[gi]), .mem_rd(mem_rd[gi]), .mem_wr(mem_wr[gi]),
                .mem_addr(mem_addr[gi]), .mem_data(mem_data[gi]), .mem_out(mem_out[gi])
            );

            always @(posedge clk)
                if (mem_en[gi] && mem_wr[gi]) arr[mem_addr[gi]] <= mem_data[gi];
            // Poison value outside read strobes exposes mistimed sampling
            assign mem_out[gi] = (mem_en[gi] && mem_rd[gi]) ? arr[mem_addr[gi]] : 32'hDEAD_BEEF;
        end
    endgenerate

    typedef struct {
        int          inst;
        bit          wr;
        logic [15:0] addr;
        logic [31:0] data;
        int          hold;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    typedef struct {
        int          inst;
        bit          wr;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input int inst, input string tag);
        check({tag, "_resp_valid"}, resp_valid[inst], 0);
        check({tag, "_busy"}, busy[inst], 0);
        check({tag, "_req_ready"}, req_ready[inst], 1);
        check({tag, "_mem_en"}, mem_en[inst], 0);
    endtask

    task automatic run_txn(input vec_t v);
        int   lat;
        bit   seen;
        int   nwr, nrd;
        exp_t e;
        @(negedge clk);
        req_wr[v.inst]     = v.wr;
        req_addr[v.inst]   = v.addr;
        req_wdata[v.inst]  = v.data;
        req_valid[v.inst]  = 1'b1;
        resp_ready[v.inst] = (v.hold == 0);
        check("req_ready_before_accept", req_ready[v.inst], 1);
        sb.push_back('{v.inst, v.wr, v.exp_rdata});
        @(posedge clk);
        #1 req_valid[v.inst] = 1'b0;
        seen = 0; lat = 0; nwr = 0; nrd = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (resp_valid[v.inst]) begin
                seen = 1;
                lat  = c;
            end else begin
                if (mem_wr[v.inst]) begin
                    nwr++;
                    check("mem_addr_on_wr", mem_addr[v.inst], v.addr);
                    check("mem_data_on_wr", mem_data[v.inst], v.data);
                end
                if (mem_rd[v.inst]) begin
                    nrd++;
                    check("mem_addr_on_rd", mem_addr[v.inst], v.addr);
                end
            end
        end
        check("resp_latency", lat, v.exp_lat);
        check("mem_wr_cycles", nwr, v.wr ? 1 : 0);
        check("mem_rd_cycles", nrd, v.wr ? 0 : v.exp_lat - 1);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            check("resp_wr", resp_wr[e.inst], e.wr);
            check("resp_rdata", resp_rdata[e.inst], e.rdata);
        end
        if (v.hold > 0) begin
            for (int h = 1; h <= v.hold; h++) begin
                if (h == 2) begin
                    req_wr[v.inst]    = 1'b1;
                    req_addr[v.inst]  = 16'h1234;
                    req_valid[v.inst] = 1'b1;
                end
                if (h == 3) req_valid[v.inst] = 1'b0;
                @(negedge clk);
                check("hold_resp_valid", resp_valid[v.inst], 1);
                check("hold_resp_rdata", resp_rdata[v.inst], v.exp_rdata);
                check("hold_req_ready", req_ready[v.inst], 0);
                check("hold_mem_en", mem_en[v.inst], 0);
            end
            req_valid[v.inst] = 1'b0;
        end
        resp_ready[v.inst] = 1'b1;
        @(negedge clk);
        check_idle(v.inst, "after_resp");
        $display("txn inst=%0d %s addr=%h data=%h rdata=%h lat=%0d",
                 v.inst, v.wr ? "WR" : "RD", v.addr, v.data, resp_rdata[v.inst], lat);
    endtask

    initial begin
        vec_t vecs[$];
        vecs.push_back('{0, 1, 16'd15,     32'd123,        0, 32'd0,          2});
        vecs.push_back('{0, 0, 16'd15,     32'd0,          0, 32'd123,        2});
        vecs.push_back('{1, 1, 16'd16,     32'd223,        0, 32'd0,          2});
        vecs.push_back('{1, 0, 16'd16,     32'd0,          0, 32'd223,        5});
        vecs.push_back('{1, 0, 16'd16,     32'd0,          5, 32'd223,        5});
        vecs.push_back('{0, 0, 16'd15,     32'd0,          5, 32'd123,        2});
        vecs.push_back('{0, 1, 16'h0000,   32'hFFFF_FFFF,  0, 32'd0,          2});
        vecs.push_back('{0, 1, 16'hFFFF,   32'h0000_0001,  0, 32'd0,          2});
        vecs.push_back('{0, 0, 16'h0000,   32'd0,          0, 32'hFFFF_FFFF,  2});
        vecs.push_back('{0, 0, 16'hFFFF,   32'd0,          0, 32'h0000_0001,  2});
        vecs.push_back('{1, 1, 16'h0000,   32'hFFFF_FFFF,  0, 32'd0,          2});
        vecs.push_back('{1, 1, 16'hFFFF,   32'h0000_0001,  0, 32'd0,          2});
        vecs.push_back('{1, 0, 16'hFFFF,   32'd0,          0, 32'h0000_0001,  5});
        vecs.push_back('{1, 0, 16'h0000,   32'd0,          0, 32'hFFFF_FFFF,  5});

        rst_n      = 2'b00;
        req_valid  = '0;
        req_wr     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_idle(i, "reset");
            check("reset_mem_rd", mem_rd[i], 0);
            check("reset_mem_wr", mem_wr[i], 0);
            check("reset_mem_addr", mem_addr[i], 0);
            check("reset_mem_data", mem_data[i], 0);
            check("reset_resp_wr", resp_wr[i], 0);
            check("reset_resp_rdata", resp_rdata[i], 0);
        end
        rst_n = 2'b11;

        for (int i = 0; i < vecs.size(); i++) run_txn(vecs[i]);

        // Reset in the second rd cycle of a RD_WAIT=3 read drops the request
        run_txn('{1, 1, 16'h0020, 32'hCAFE_0020, 0, 32'd0, 2});
        @(negedge clk);
        req_wr[1]    = 1'b0;
        req_addr[1]  = 16'h0020;
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        check("abort_rd_cycle1", mem_rd[1], 1);
        @(negedge clk);
        check("abort_rd_cycle2", mem_rd[1], 1);
        rst_n[1] = 1'b0;
        @(posedge clk);
        #1 rst_n[1] = 1'b1;
        @(negedge clk);
        check_idle(1, "abort");
        check("abort_mem_rd", mem_rd[1], 0);
        $display("txn inst=1 RD addr=0020 aborted by reset");
        run_txn('{1, 0, 16'h0020, 32'd0, 0, 32'hCAFE_0020, 5});

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
